ddr5_cmd_issuer: RTL and testbench

// Consumes one decoded CPU trace request at a time (cycle, core, opn, 34-bit addr) from the trace front end.

---
 rtl/ddr5_cmd_issuer.sv | 174 +++++++++++++++++
 tb/tb_ddr5_cmd_issuer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr5_cmd_issuer.sv
// Closed-page DDR5 command issuer: one trace request at a time becomes ACT0/ACT1 -> RD/WR pair -> PRE.
// Timing gaps between commands come from a single 8-bit wait down-counter.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | ready for a request, no command
// S_ACT0     | ACT0 on the bus
// S_ACT1     | ACT1 on the bus
// S_WAIT_RCD | waiting out tRCD before the CAS pair
// S_CAS0     | RD0 or WR0 on the bus
// S_CAS1     | RD1 or WR1 on the bus
// S_WAIT_PRE | waiting out tRTP / tWRP before PRE
// S_PRE      | PRE on the bus
// S_WAIT_RP  | waiting out tRP before accepting again
module ddr5_cmd_issuer #(
    parameter int ADDR_WIDTH    = 34,
    parameter int CPU_CYC_WIDTH = 64,
    parameter int CORE_WIDTH    = 4,
    parameter int OPN_WIDTH     = 3,
    parameter int TRCD          = 39,
    parameter int TRTP          = 18,
    parameter int TWRP          = 76,
    parameter int TRP           = 39
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CPU_CYC_WIDTH-1:0] req_cpu_cyc,
    input  logic [CORE_WIDTH-1:0]    req_core,
    input  logic [OPN_WIDTH-1:0]     req_opn,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_code,
    output logic                     cmd_ch,
    output logic [2:0]               cmd_bg,
    output logic [1:0]               cmd_ba,
    output logic [15:0]              cmd_row,
    output logic [9:0]               cmd_col,
    output logic [CORE_WIDTH-1:0]    cmd_core,
    output logic [CPU_CYC_WIDTH-1:0] cmd_cyc,
    output logic                     busy,
    output logic                     err_opn
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    localparam logic [2:0] C_NOP = 3'd0, C_ACT0 = 3'd1, C_ACT1 = 3'd2, C_RD0 = 3'd3,
                           C_RD1 = 3'd4, C_WR0 = 3'd5, C_WR1 = 3'd6, C_PRE = 3'd7;

    // Wait states cover gap-2 cycles; the counter runs load..0 inclusive, hence gap-3.
    localparam logic [7:0] RCD_LOAD = 8'(TRCD - 3);
    localparam logic [7:0] RTP_LOAD = 8'(TRTP - 3);
    localparam logic [7:0] WRP_LOAD = 8'(TWRP - 3);
    localparam logic [7:0] RP_LOAD  = 8'(TRP - 3);
    localparam logic [CPU_CYC_WIDTH-1:0] CYC_ONE = 1;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       is_wr;

    logic       opn_legal;
    logic [7:0] pre_load;
    logic       pre_short;

    assign opn_legal = (req_opn <= OPN_WIDTH'(2));
    assign pre_load  = is_wr ? WRP_LOAD : RTP_LOAD;
    assign pre_short = is_wr ? (TWRP <= 2) : (TRTP <= 2);

    // Request timestamp and byte offset carry no meaning for command generation.
    logic unused_ok;
    assign unused_ok = ^{req_cpu_cyc, req_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            is_wr     <= 1'b0;
            req_ready <= 1'b1;
            cmd_valid <= 1'b0;
            cmd_code  <= C_NOP;
            cmd_ch    <= 1'b0;
            cmd_bg    <= 3'd0;
            cmd_ba    <= 2'd0;
            cmd_row   <= 16'd0;
            cmd_col   <= 10'd0;
            cmd_core  <= '0;
            cmd_cyc   <= '0;
            busy      <= 1'b0;
            err_opn   <= 1'b0;
        end else begin
            cmd_cyc   <= cmd_cyc + CYC_ONE;
            err_opn   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code  <= C_NOP;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (opn_legal) begin
                            cmd_row   <= req_addr[33:18];
                            cmd_col   <= {req_addr[17:12], req_addr[5:2]};
                            cmd_ba    <= req_addr[11:10];
                            cmd_bg    <= req_addr[9:7];
                            cmd_ch    <= req_addr[6];
                            cmd_core  <= req_core;
                            is_wr     <= (req_opn == OPN_WIDTH'(1));
                            state     <= S_ACT0;
                            cmd_valid <= 1'b1;
                            cmd_code  <= C_ACT0;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            err_opn   <= 1'b1;
                        end
                    end
                end
                S_ACT0: begin
                    state     <= S_ACT1;
                    cmd_valid <= 1'b1;
                    cmd_code  <= C_ACT1;
                end
                S_ACT1, S_WAIT_RCD: begin
                    if ((state == S_ACT1 && TRCD <= 2) || (state == S_WAIT_RCD && wait_cnt == 8'd0)) begin
                        state     <= S_CAS0;
                        cmd_valid <= 1'b1;
                        cmd_code  <= is_wr ? C_WR0 : C_RD0;
                    end else if (state == S_ACT1) begin
                        state    <= S_WAIT_RCD;
                        wait_cnt <= RCD_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_CAS0: begin
                    state     <= S_CAS1;
                    cmd_valid <= 1'b1;
                    cmd_code  <= is_wr ? C_WR1 : C_RD1;
                end
                S_CAS1, S_WAIT_PRE: begin
                    if ((state == S_CAS1 && pre_short) || (state == S_WAIT_PRE && wait_cnt == 8'd0)) begin
                        state     <= S_PRE;
                        cmd_valid <= 1'b1;
                        cmd_code  <= C_PRE;
                    end else if (state == S_CAS1) begin
                        state    <= S_WAIT_PRE;
                        wait_cnt <= pre_load;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_PRE, S_WAIT_RP: begin
                    if ((state == S_PRE && TRP <= 2) || (state == S_WAIT_RP && wait_cnt == 8'd0)) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (state == S_PRE) begin
                        state    <= S_WAIT_RP;
                        wait_cnt <= RP_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
// Directed bench for ddr5_cmd_issuer: default timing instance plus a minimum-timing instance.
module tb_ddr5_cmd_issuer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid, req_ready;
    logic [63:0] req_cpu_cyc;
    logic [3:0]  req_core;
    logic [2:0]  req_opn;
    logic [33:0] req_addr;
    logic        cmd_valid, cmd_ch, busy, err_opn;
    logic [2:0]  cmd_code, cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [3:0]  cmd_core;
    logic [63:0] cmd_cyc;

    logic        b_req_valid, b_req_ready;
    logic [63:0] b_req_cpu_cyc;
    logic [3:0]  b_req_core;
    logic [2:0]  b_req_opn;
    logic [33:0] b_req_addr;
    logic        b_cmd_valid, b_cmd_ch, b_busy, b_err_opn;
    logic [2:0]  b_cmd_code, b_cmd_bg;
    logic [1:0]  b_cmd_ba;
    logic [15:0] b_cmd_row;
    logic [9:0]  b_cmd_col;
    logic [3:0]  b_cmd_core;
    logic [63:0] b_cmd_cyc;

    ddr5_cmd_issuer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cpu_cyc(req_cpu_cyc), .req_core(req_core), .req_opn(req_opn), .req_addr(req_addr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ch(cmd_ch), .cmd_bg(cmd_bg),
        .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_core(cmd_core),
        .cmd_cyc(cmd_cyc), .busy(busy), .err_opn(err_opn)
    );

    ddr5_cmd_issuer #(.TRCD(2), .TRTP(2), .TRP(2)) dut_min (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_cpu_cyc(b_req_cpu_cyc), .req_core(b_req_core), .req_opn(b_req_opn), .req_addr(b_req_addr),
        .cmd_valid(b_cmd_valid), .cmd_code(b_cmd_code), .cmd_ch(b_cmd_ch), .cmd_bg(b_cmd_bg),
        .cmd_ba(b_cmd_ba), .cmd_row(b_cmd_row), .cmd_col(b_cmd_col), .cmd_core(b_cmd_core),
        .cmd_cyc(b_cmd_cyc), .busy(b_busy), .err_opn(b_err_opn)
    );

    typedef struct {
        int          c;
        logic [2:0]  code;
        logic        ch;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
        logic [3:0]  core;
    } ev_t;

    ev_t        q[$];
    int         q2c[$];
    logic [2:0] q2k[$];

    always @(negedge clk) begin : mon
        ev_t e;
        if (cmd_valid) begin
            e.c = cyc; e.code = cmd_code; e.ch = cmd_ch; e.bg = cmd_bg; e.ba = cmd_ba;
            e.row = cmd_row; e.col = cmd_col; e.core = cmd_core;
            q.push_back(e);
        end
        if (b_cmd_valid) begin
            q2c.push_back(cyc);
            q2k.push_back(b_cmd_code);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_cmd(input string tag, input int idx, input int c, input logic [2:0] code);
        if (idx >= q.size()) check_val({tag, " present"}, 64'(q.size()), 64'(idx + 1));
        else begin
            check_val({tag, " cyc"}, 64'(q[idx].c), 64'(c));
            check_val({tag, " code"}, 64'(q[idx].code), 64'(code));
        end
    endtask

    task automatic exp_map(input string tag, input int idx, input logic ch, input logic [2:0] bg,
                           input logic [1:0] ba, input logic [15:0] row, input logic [9:0] col,
                           input logic [3:0] core);
        if (idx >= q.size()) check_val({tag, " present"}, 64'(q.size()), 64'(idx + 1));
        else begin
            check_val({tag, " ch"}, 64'(q[idx].ch), 64'(ch));
            check_val({tag, " bg"}, 64'(q[idx].bg), 64'(bg));
            check_val({tag, " ba"}, 64'(q[idx].ba), 64'(ba));
            check_val({tag, " row"}, 64'(q[idx].row), 64'(row));
            check_val({tag, " col"}, 64'(q[idx].col), 64'(col));
            check_val({tag, " core"}, 64'(q[idx].core), 64'(core));
        end
    endtask

    task automatic wait_ready(input int maxc, output int t);
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check_val("ready timeout", 64'd0, 64'd1);
    endtask

    // Presents a request on a negedge with req_ready high; t is the accept cycle.
    task automatic send(input logic [2:0] opn, input logic [33:0] addr, input logic [3:0] core, output int t);
        wait_ready(300, t);
        req_opn = opn; req_addr = addr; req_core = core;
        req_cpu_cyc = 64'(cyc) * 3;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    localparam logic [33:0] ADDR1 = 34'h0_0003_0C8C;
    localparam logic [33:0] ADDR2 = {16'hABCD, 6'h15, 2'b10, 3'b101, 1'b1, 4'h9, 2'b11};

    int t, t2, tr;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        req_valid = 0; req_cpu_cyc = 0; req_core = 0; req_opn = 0; req_addr = 0;
        b_req_valid = 0; b_req_cpu_cyc = 0; b_req_core = 0; b_req_opn = 0; b_req_addr = 0;

        repeat (3) @(negedge clk);
        check_val("rst req_ready", 64'(req_ready), 64'd1);
        check_val("rst cmd_valid", 64'(cmd_valid), 64'd0);
        check_val("rst cmd_code", 64'(cmd_code), 64'd0);
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst err_opn", 64'(err_opn), 64'd0);
        check_val("rst cmd_cyc", cmd_cyc, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("cmd_cyc count", cmd_cyc, 64'd3);

        // Read: ACT0 t+1, ACT1 t+2, RD0 t+40, RD1 t+41, PRE t+58, ready again t+96
        q.delete();
        send(3'd0, ADDR1, 4'h3, t);
        check_val("rd busy", 64'(busy), 64'd1);
        wait_ready(300, tr);
        check_val("rd ready return", 64'(tr), 64'(t + 96));
        check_val("rd ncmd", 64'(q.size()), 64'd5);
        exp_cmd("rd act0", 0, t + 1, 3'd1);
        exp_cmd("rd act1", 1, t + 2, 3'd2);
        exp_cmd("rd rd0", 2, t + 40, 3'd3);
        exp_cmd("rd rd1", 3, t + 41, 3'd4);
        exp_cmd("rd pre", 4, t + 58, 3'd7);
        exp_map("rd map act0", 0, 1'b0, 3'd1, 2'd3, 16'h0000, 10'h303, 4'h3);
        exp_map("rd map pre", 4, 1'b0, 3'd1, 2'd3, 16'h0000, 10'h303, 4'h3);

        // Write: WR0 A+39, WR1 A+40, PRE A+115
        q.delete();
        send(3'd1, ADDR1, 4'h7, t);
        wait_ready(300, tr);
        check_val("wr ready return", 64'(tr), 64'(t + 1 + 115 + 38));
        check_val("wr ncmd", 64'(q.size()), 64'd5);
        exp_cmd("wr act0", 0, t + 1, 3'd1);
        exp_cmd("wr act1", 1, t + 2, 3'd2);
        exp_cmd("wr wr0", 2, t + 40, 3'd5);
        exp_cmd("wr wr1", 3, t + 41, 3'd6);
        exp_cmd("wr pre", 4, t + 116, 3'd7);

        // Back-to-back reads with valid held: second ACT0 at PRE+39
        q.delete();
        wait_ready(300, t);
        req_opn = 3'd0; req_addr = ADDR1; req_core = 4'h1; req_valid = 1'b1;
        t2 = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t2 = cyc;
                break;
            end
        end
        req_addr = ADDR2; req_core = 4'h9;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("b2b ready low span", 64'(t2), 64'(t + 96));
        wait_ready(300, tr);
        check_val("b2b ncmd", 64'(q.size()), 64'd10);
        exp_cmd("b2b pre1", 4, t + 58, 3'd7);
        exp_cmd("b2b act0 2nd", 5, t + 58 + 39, 3'd1);
        exp_map("b2b map 2nd", 5, 1'b1, 3'd5, 2'd2, 16'hABCD, 10'h159, 4'h9);
        exp_map("b2b map rd0 2nd", 7, 1'b1, 3'd5, 2'd2, 16'hABCD, 10'h159, 4'h9);

        // Illegal opn then ifetch
        q.delete();
        send(3'd5, ADDR1, 4'h2, t);
        check_val("ill err_opn", 64'(err_opn), 64'd1);
        check_val("ill cmd_valid", 64'(cmd_valid), 64'd0);
        check_val("ill req_ready", 64'(req_ready), 64'd1);
        check_val("ill busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_val("ill err pulse end", 64'(err_opn), 64'd0);
        send(3'd2, ADDR2, 4'h4, t);
        wait_ready(300, tr);
        check_val("if ncmd", 64'(q.size()), 64'd5);
        exp_cmd("if rd0", 2, t + 40, 3'd3);
        exp_cmd("if rd1", 3, t + 41, 3'd4);
        exp_map("if map", 2, 1'b1, 3'd5, 2'd2, 16'hABCD, 10'h159, 4'h4);

        // Reset during WAIT_RCD
        q.delete();
        send(3'd0, ADDR1, 4'h5, t);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid rst cmd_cyc", cmd_cyc, 64'd0);
        check_val("mid rst req_ready", 64'(req_ready), 64'd1);
        check_val("mid rst busy", 64'(busy), 64'd0);
        check_val("mid rst cmd_valid", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        repeat (60) @(negedge clk);
        check_val("post rst no cmds", 64'(q.size()), 64'd0);
        check_val("post rst ready", 64'(req_ready), 64'd1);
        check_val("post rst cmd_cyc", cmd_cyc, 64'd60);

        // Minimum timing instance, back-to-back: ACT0 A, RD0 A+2, PRE A+4, next ACT0 A+6
        q2c.delete(); q2k.delete();
        @(negedge clk);
        b_req_opn = 3'd0; b_req_addr = ADDR1; b_req_core = 4'h6; b_req_valid = 1'b1;
        t = cyc;
        t2 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_req_ready) begin
                t2 = cyc;
                break;
            end
        end
        @(negedge clk);
        b_req_valid = 1'b0;
        repeat (20) @(negedge clk);
        check_val("min ready return", 64'(t2), 64'(t + 6));
        check_val("min ncmd", 64'(q2c.size()), 64'd10);
        if (q2c.size() >= 6) begin
            check_val("min act0 cyc", 64'(q2c[0]), 64'(t + 1));
            check_val("min rd0 cyc", 64'(q2c[2]), 64'(t + 3));
            check_val("min rd0 code", 64'(q2k[2]), 64'd3);
            check_val("min pre cyc", 64'(q2c[4]), 64'(t + 5));
            check_val("min pre code", 64'(q2k[4]), 64'd7);
            check_val("min act0b cyc", 64'(q2c[5]), 64'(t + 7));
            check_val("min act0b code", 64'(q2k[5]), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
